// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round-transform helpers for the forward cipher.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 10;
    localparam logic [7:0]  GF_POLY        = 8'h1B;

    typedef logic [127:0]     aes_state_t;
    typedef logic [15:0][7:0] aes_bytes_t;

    typedef enum logic {
        IDLE,
        ROUND
    } enc_fsm_e;

    // Indexed directly by the round counter; unused slots read as zero.
    localparam logic [15:0][7:0] RCON_TBL = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; byte index is row + 4*column.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[8*(15-(row+4*c)) +: 8] = s[8*(15-(row+4*((c+row)%4))) +: 8];
            end
        end
        return r;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c)   +: 8];
            a1 = s[8*(14-4*c)   +: 8];
            a2 = s[8*(13-4*c)   +: 8];
            a3 = s[8*(12-4*c)   +: 8];
            r[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (single byte lookup).
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Byte 0 of the table is the most significant byte, so entry a sits at (255-a)*8.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/encryption_block.sv
// Iterative AES-128 encryptor: one round per clock with an on-the-fly key schedule.
// Optional macro ENC_LAST_KEY_OUT_EN exposes the final round key on last_round_key.
module encryption_block
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable_encrypt,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic [127:0] final_data_out,
    output logic [3:0]   enc_count_out,
    output logic         enc_busy,
    output logic         enc_done
`ifdef ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0] last_round_key
`endif
);

    localparam logic [3:0] LAST_ROUND = NUM_ROUNDS[3:0];

    enc_fsm_e   fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    aes_state_t rkey_q, rkey_d;
    aes_state_t final_q, final_d;
    logic [3:0] count_q, count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    aes_state_t sub_bytes;
    aes_state_t shifted;
    aes_state_t mixed;
    aes_state_t round_out;
    aes_state_t rk_next;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] key_temp;

    for (genvar g = 0; g < 16; g++) begin : g_subbytes
        aes_sbox u_sbox (
            .in_i  (state_q[8*g +: 8]),
            .out_o (sub_bytes[8*g +: 8])
        );
    end

    assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rot_word[8*g +: 8]),
            .out_o (sub_word[8*g +: 8])
        );
    end

    assign key_temp           = sub_word ^ {RCON_TBL[count_q], 24'h000000};
    assign rk_next[127:96]    = rkey_q[127:96] ^ key_temp;
    assign rk_next[95:64]     = rkey_q[95:64]  ^ rk_next[127:96];
    assign rk_next[63:32]     = rkey_q[63:32]  ^ rk_next[95:64];
    assign rk_next[31:0]      = rkey_q[31:0]   ^ rk_next[63:32];

    assign shifted   = shift_rows(sub_bytes);
    assign mixed     = (count_q == LAST_ROUND) ? shifted : mix_columns(shifted);
    assign round_out = mixed ^ rk_next;

`ifdef ENC_LAST_KEY_OUT_EN
    aes_state_t lrk_q, lrk_d;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        final_d = final_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ENC_LAST_KEY_OUT_EN
        lrk_d   = lrk_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (enable_encrypt) begin
                    state_d = data_in ^ key_in;
                    rkey_d  = key_in;
                    count_d = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                rkey_d  = rk_next;
                count_d = count_q + 4'd1;
                if (count_q == LAST_ROUND) begin
                    final_d = round_out;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    count_d = '0;
                    fsm_d   = IDLE;
`ifdef ENC_LAST_KEY_OUT_EN
                    lrk_d   = rk_next;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            final_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENC_LAST_KEY_OUT_EN
            lrk_q   <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            final_q <= final_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ENC_LAST_KEY_OUT_EN
            lrk_q   <= lrk_d;
`endif
        end
    end

    assign final_data_out = final_q;
    assign enc_count_out  = count_q;
    assign enc_busy       = busy_q;
    assign enc_done       = done_q;
`ifdef ENC_LAST_KEY_OUT_EN
    assign last_round_key = lrk_q;
`endif

endmodule

// File: tb/tb_encryption_block.sv
// Scoreboard bench for encryption_block using FIPS-197 known-answer vectors.
module tb_encryption_block;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LRK_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LRK_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         enable_encrypt = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] data_in = '0;
    logic [127:0] final_data_out;
    logic [3:0]   enc_count_out;
    logic         enc_busy;
    logic         enc_done;
`ifdef ENC_LAST_KEY_OUT_EN
    logic [127:0] last_round_key;
`endif

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] lrk;
        int unsigned  done_cyc;
    } exp_t;
    exp_t sb_q[$];

    encryption_block #(.NUM_ROUNDS(10)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .enable_encrypt (enable_encrypt),
        .key_in         (key_in),
        .data_in        (data_in),
        .final_data_out (final_data_out),
        .enc_count_out  (enc_count_out),
        .enc_busy       (enc_busy),
        .enc_done       (enc_done)
`ifdef ENC_LAST_KEY_OUT_EN
        ,
        .last_round_key (last_round_key)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (enc_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 128'(enc_done), 128'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ciphertext", final_data_out, e.ct);
                check("done_cycle", 128'(cyc), 128'(e.done_cyc));
`ifdef ENC_LAST_KEY_OUT_EN
                check("last_round_key", last_round_key, e.lrk);
`endif
            end
        end
    end

    // Caller is at a negedge; start is sampled at the next posedge.
    task automatic issue(input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] ct, input logic [127:0] lrk);
        exp_t e;
        enable_encrypt = 1'b1;
        key_in  = k;
        data_in = p;
        e.ct = ct;
        e.lrk = lrk;
        e.done_cyc = cyc + 11;
        sb_q.push_back(e);
        @(negedge clk);
        enable_encrypt = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (enc_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 128'(seen), 128'd1);
    endtask

    initial begin
        logic seen6;

        repeat (3) @(negedge clk);
        check("rst_data", final_data_out, '0);
        check("rst_count", 128'(enc_count_out), 128'd0);
        check("rst_busy", 128'(enc_busy), 128'd0);
        check("rst_done", 128'(enc_done), 128'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Round counter walk plus an ignored mid-operation start.
        issue(KEY_B, PT_B, CT_B, LRK_B);
        for (int k = 1; k <= 10; k++) begin
            check("count_step", 128'(enc_count_out), 128'(k));
            check("busy_high", 128'(enc_busy), 128'd1);
            if (k == 5) begin
                enable_encrypt = 1'b1;
                key_in  = 128'hdeadbeef0123456789abcdeffedcba98;
                data_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
            end else begin
                enable_encrypt = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_low_after", 128'(enc_busy), 128'd0);
        check("count_idle_after", 128'(enc_count_out), 128'd0);
        @(negedge clk);

        issue(KEY_C, PT_C, CT_C, LRK_C);
        wait_done();
        @(negedge clk);

        // Back-to-back: restart in the done cycle.
        issue(KEY_B, PT_B, CT_B, LRK_B);
        wait_done();
        issue(KEY_C, PT_C, CT_C, LRK_C);
        wait_done();
        @(negedge clk);

        // Reset abort at round 6.
        issue(KEY_B, PT_B, CT_B, LRK_B);
        seen6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (enc_count_out == 4'd6) begin
                seen6 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_count6", 128'(seen6), 128'd1);
        n_rst = 1'b0;
        #1;
        void'(sb_q.pop_back());
        check("abort_data", final_data_out, '0);
        check("abort_count", 128'(enc_count_out), 128'd0);
        check("abort_busy", 128'(enc_busy), 128'd0);
        check("abort_done", 128'(enc_done), 128'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        issue(KEY_B, PT_B, CT_B, LRK_B);
        wait_done();

        // Idle hold with toggling inputs.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            data_in = {$urandom, $urandom, $urandom, $urandom};
            check("hold_data", final_data_out, CT_B);
            check("hold_done", 128'(enc_done), 128'd0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encryption_block.md
Name: encryption_block

Overview:
Iterative AES-128 encryption engine. It is the forward counterpart to the existing decryption path and sits on the SD-card write side, encrypting each 128-bit block before it leaves the chip. It computes one full round per clock and runs an on-the-fly forward key schedule, so only the cipher key is required. A start/busy/done handshake connects it to the card-write controller.

Parameters:
NUM_ROUNDS, 10, round count; only 10 (AES-128) is supported, and it sets the round-counter terminal value.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable_encrypt  input  1  start strobe; sampled only when idle
key_in  input  128  cipher key; [127:120] is key byte 0 (FIPS-197 order)
data_in  input  128  plaintext; [127:120] is state byte 0, column-major
final_data_out  output  128  ciphertext; registered, held until the next completion
enc_count_out  output  4  current round number (0 when idle)
enc_busy  output  1  high while rounds are in progress
enc_done  output  1  one-cycle pulse when final_data_out is updated

Behaviour:
- Reset values (asynchronous, n_rst low): final_data_out=0, enc_count_out=0, enc_busy=0, enc_done=0, internal state/round-key registers=0, FSM=IDLE. Reset mid-operation aborts immediately; no done pulse follows.
- FSM states: IDLE, ROUND.
- IDLE with enable_encrypt=1, at edge E0:
  - state_reg <= data_in ^ key_in (round-0 AddRoundKey); rkey_reg <= key_in.
  - count <= 1; enc_busy <= 1; go to ROUND.
- ROUND, each edge:
  - rk_next = KeyExpand(rkey_reg, RCON[count]).
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk_next).
  - MixColumns is skipped when count==NUM_ROUNDS.
  - rkey_reg <= rk_next; count <= count+1.
- Edge where count==NUM_ROUNDS is processed (E10):
  - final_data_out <= round result; enc_done <= 1 for exactly one cycle.
  - enc_busy <= 0; count <= 0; go to IDLE.
- Latency: start sampled at E0, enc_done visible after E10, i.e. 10 cycles after the start edge and 11 cycles including the start cycle. Throughput is one block per 11 cycles.
- enable_encrypt while enc_busy=1 is ignored; it is neither queued nor allowed to corrupt the operation.
- enable_encrypt high in the same cycle enc_done is high: accepted, because the FSM is already IDLE. This gives back-to-back operation.
- Holding enable_encrypt high continuously restarts immediately after each completion.
- key_in and data_in are don't-care except at the start edge.
- final_data_out changes only at the completion edge.
- KeyExpand(w): temp = SubWord(RotWord(w[31:0])) ^ {RCON,24'h0}; w0'=w[127:96]^temp; w1'=w[95:64]^w0'; w2'=w[63:32]^w1'; w3'=w[31:0]^w2'.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- GF(2^8) arithmetic uses polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).

Optional Feature:
ENC_LAST_KEY_OUT_EN
- Defined: adds output last_round_key [127:0] (reset 0), loaded with rk_next at the completion edge. It holds round-10 key material that the decryption path uses as its starting curr_key.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - state typedef (16x8 byte array / 128-bit)
  - RCON table
  - GF constant 8'h1B
  - xtime function
  - NUM_ROUNDS default
- One sub-module, aes_sbox: combinational 8-bit forward S-box. It is instantiated 16 times for SubBytes and 4 times for SubWord.
- ShiftRows and MixColumns are functions in the package or local, not modules.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, start pulse → enc_done after 10 cycles, final_data_out=3925841d02dc09fbdc118597196a0b32; with ENC_LAST_KEY_OUT_EN, last_round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a; last_round_key=13111d7fe3944a17f307a78b4d2b30c5.
- Handshake timing: enc_count_out steps 1..10 while enc_busy=1. Pulse enable_encrypt at count 5 with different data → ignored, result still the App. B ciphertext.
- Back-to-back: assert enable_encrypt in the enc_done cycle with App. C.1 inputs → second enc_done exactly 11 cycles after the first, correct ciphertext both times.
- Reset abort: drop n_rst at count 6 → all outputs 0 immediately, no enc_done. A new start after release yields the correct App. B result.
- Hold: after completion, toggle key_in/data_in for 20 idle cycles → final_data_out unchanged, enc_done stays 0.
